// File: rtl/kgp_imem_pkg.sv
// Shared widths, the halt sentinel and FSM state encodings for the boot arbiter.
// Combinational definitions only; no timing or handshake of its own.
package kgp_imem_pkg;
   localparam int          ADDR_W    = 6;
   localparam int          DATA_W    = 32;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_WRITE = 3'd1,
      ST_TERM  = 3'd2,
      ST_RUN   = 3'd3,
      ST_HALT  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;
endpackage

// File: rtl/imem_byte_packer.sv
// Packs loader bytes big-endian into 32-bit words; word_valid flags the cycle the 4th byte lands.
// Zero latency on word_valid/partial; accepts a byte whenever take is high.
module imem_byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        take,
   input  logic        clear,
   input  logic [7:0]  ld_byte,
   output logic [31:0] word,
   output logic        word_valid,
   output logic        partial
);
   logic [1:0]  byte_cnt;
   logic [31:0] shreg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt <= 2'd0;
         shreg    <= 32'd0;
      end else if (take) begin
         shreg    <= {shreg[23:0], ld_byte};
         byte_cnt <= byte_cnt + 2'd1;
      end else if (clear) begin
         byte_cnt <= 2'd0;
      end
   end

   assign word       = shreg;
   assign word_valid = take && (byte_cnt == 2'd3);
   // Reflects the count after this cycle's byte, so a same-cycle ld_done sees it.
   assign partial    = take || (byte_cnt != 2'd0);
endmodule

// File: rtl/imem_boot_arbiter.sv
// Owns the instruction memory port: boot-loads packed words plus sentinel, then serves fetches.
// Fetch latency 1 cycle, back-to-back; loader stalled (ld_ready=0) outside LOAD.
module imem_boot_arbiter
   import kgp_imem_pkg::*;
#(
   parameter int                ADDR_W    = kgp_imem_pkg::ADDR_W,
   parameter int                DATA_W    = kgp_imem_pkg::DATA_W,
   parameter logic [DATA_W-1:0] HALT_WORD = kgp_imem_pkg::HALT_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   output logic              ld_ready,
   input  logic              ld_done,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_instr,
   output logic              fetch_valid,
   output logic              fetch_halt,
   output logic              cpu_run,
   output logic              load_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic              term_pend;
   logic              take;
   logic [31:0]       word;
   logic              word_valid;
   logic              partial;

   assign take = ld_valid && (state == ST_LOAD);

   imem_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .take       (take),
      .clear      (state == ST_WRITE),
      .ld_byte    (ld_byte),
      .word       (word),
      .word_valid (word_valid),
      .partial    (partial)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_LOAD;
         wr_ptr      <= '0;
         term_pend   <= 1'b0;
         fetch_instr <= '0;
         fetch_valid <= 1'b0;
      end else begin
         fetch_valid <= 1'b0;
         case (state)
            ST_LOAD: begin
               // An ld_done arriving with the 4th byte is remembered and honoured after the write.
               if (word_valid) begin
                  state     <= ST_WRITE;
                  term_pend <= ld_done;
               end else if (ld_done) begin
                  state <= partial ? ST_ERR : ST_TERM;
               end
            end
            ST_WRITE: begin
               wr_ptr    <= wr_ptr + PTR_ONE;
               term_pend <= 1'b0;
               if (wr_ptr == '1)   state <= ST_RUN;
               else if (term_pend) state <= ST_TERM;
               else                state <= ST_LOAD;
            end
            ST_TERM: state <= ST_RUN;
            ST_RUN: begin
               if (fetch_req) begin
                  if (mem_rdata == HALT_WORD) begin
                     fetch_instr <= '0;
                     state       <= ST_HALT;
                  end else begin
                     fetch_instr <= mem_rdata;
                     fetch_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ld_ready   = (state == ST_LOAD);
   assign cpu_run    = (state == ST_RUN);
   assign fetch_halt = (state == ST_HALT);
   assign load_err   = (state == ST_ERR);
   assign mem_we     = (state == ST_WRITE) || (state == ST_TERM);
   assign mem_addr   = (state == ST_RUN) ? fetch_addr : wr_ptr;
   assign mem_wdata  = (state == ST_WRITE) ? word :
                       (state == ST_TERM)  ? HALT_WORD : '0;
endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Randomised bench for imem_boot_arbiter: reference load/fetch model feeds write and fetch scoreboards.
module tb_imem_boot_arbiter;
   localparam int          DEPTH = 64;
   localparam logic [31:0] HW    = 32'hFFFF_FFFF;

   typedef logic [7:0] bq_t[$];
   typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
   typedef struct { bit halt; logic [31:0] d; int cyc; } fr_t;

   logic        clk, rst_n, ld_valid, ld_ready, ld_done, fetch_req;
   logic [7:0]  ld_byte;
   logic [5:0]  fetch_addr, mem_addr;
   logic [31:0] fetch_instr, mem_wdata, mem_rdata;
   logic        fetch_valid, fetch_halt, cpu_run, load_err, mem_we;

   imem_boot_arbiter dut (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
      .ld_done(ld_done), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .fetch_halt(fetch_halt),
      .cpu_run(cpu_run), .load_err(load_err), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int  n_chk = 0, n_fail = 0;
   bit  halted_m = 0;
   bit  prev_halt = 0;
   wr_t exp_wr[$];
   fr_t exp_f[$];
   wr_t we_e;
   fr_t fe_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event did not occur within bound (t=%0t)", name, $time);
   endtask

   // Write scoreboard
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         if (exp_wr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_write: addr %0d data %h, none expected", mem_addr, mem_wdata);
         end else begin
            we_e = exp_wr.pop_front();
            chk("write_addr", {26'd0, mem_addr}, {26'd0, we_e.a});
            chk("write_data", mem_wdata, we_e.d);
         end
      end
   end

   // Fetch scoreboard
   always @(negedge clk) begin
      if (fetch_valid) begin
         if (exp_f.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_fetch: instr %h, none expected", fetch_instr);
         end else begin
            fe_e = exp_f.pop_front();
            chk("fetch_kind_halt", {31'd0, 1'b0}, {31'd0, fe_e.halt});
            chk("fetch_instr", fetch_instr, fe_e.d);
            chk("fetch_latency", cyc, fe_e.cyc);
         end
      end
      if (fetch_halt && !prev_halt) begin
         if (exp_f.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_halt: fetch_halt rose with no sentinel fetch expected");
         end else begin
            fe_e = exp_f.pop_front();
            chk("halt_kind", 32'd1, {31'd0, fe_e.halt});
            chk("halt_instr_zero", fetch_instr, 32'd0);
            chk("halt_valid_low", {31'd0, fetch_valid}, 32'd0);
            chk("halt_latency", cyc, fe_e.cyc);
         end
      end
      prev_halt = fetch_halt;
   end

   // Reference: image = consecutive big-endian words, capped at DEPTH; a clean ld_done adds the sentinel.
   task automatic model_load(input bq_t b, input bit done, output bit exp_err);
      int nw, rem;
      logic [31:0] w;
      nw = b.size() / 4;
      rem = b.size() % 4;
      exp_err = 0;
      for (int i = 0; i < nw && i < DEPTH; i++) begin
         w = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
         ref_mem[i] = w;
         exp_wr.push_back('{a: i[5:0], d: w});
      end
      if (nw < DEPTH && done) begin
         if (rem == 0) begin
            ref_mem[nw] = HW;
            exp_wr.push_back('{a: nw[5:0], d: HW});
         end else begin
            exp_err = 1;
         end
      end
   endtask

   task automatic wait_accept(input string name);
      int t;
      bit acc;
      t = 0; acc = 0;
      while (!acc && t < 50) begin
         @(negedge clk); acc = ld_ready;
         @(posedge clk); #1;
         t++;
      end
      if (!acc) fail_now(name);
   endtask

   // mode: 0 no ld_done, 1 ld_done pulse after last byte, 2 ld_done with last byte
   task automatic drive_load(input bq_t b, input int mode);
      for (int i = 0; i < b.size(); i++) begin
         ld_valid = 1'b1;
         ld_byte  = b[i];
         ld_done  = (mode == 2) && (i == b.size() - 1);
         wait_accept("byte_accept");
      end
      ld_valid = 1'b0;
      ld_done  = 1'b0;
      if (mode == 1) begin
         ld_done = 1'b1;
         wait_accept("done_accept");
         ld_done = 1'b0;
      end
   endtask

   task automatic wait_run();
      int t;
      t = 0;
      @(negedge clk);
      while (!cpu_run && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("cpu_run_rise", {31'd0, cpu_run}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_fetch(input logic [5:0] addr, input bit req);
      fetch_req  = req;
      fetch_addr = addr;
      if (req && !halted_m) begin
         if (ref_mem[addr] == HW) begin
            exp_f.push_back('{halt: 1'b1, d: 32'd0, cyc: cyc + 1});
            halted_m = 1;
         end else begin
            exp_f.push_back('{halt: 1'b0, d: ref_mem[addr], cyc: cyc + 1});
         end
      end
      @(posedge clk); #1;
      fetch_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      halted_m = 0;
   endtask

   task automatic queues_empty(input string name);
      chk({name, "_writes_drained"}, exp_wr.size(), 32'd0);
      chk({name, "_fetches_drained"}, exp_f.size(), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t b;
      bit  err;
      logic [31:0] v;
      int  nw;

      rst_n = 1'b0; ld_valid = 1'b0; ld_byte = 8'd0; ld_done = 1'b0;
      fetch_req = 1'b0; fetch_addr = 6'd0;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         if (v == HW) v = 32'd0;
         mem[i] = v;
         ref_mem[i] = v;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("rst_fetch_instr", fetch_instr, 32'd0);
      chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_fetch_halt", {31'd0, fetch_halt}, 32'd0);
      chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
      chk("rst_load_err", {31'd0, load_err}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed two-word image, then fetch through to the sentinel
      b = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      model_load(b, 1'b1, err);
      drive_load(b, 1);
      @(negedge clk);
      chk("term_cycle_we", {31'd0, mem_we}, 32'd1);
      chk("term_cycle_run_low", {31'd0, cpu_run}, 32'd0);
      @(negedge clk);
      chk("run_after_term", {31'd0, cpu_run}, 32'd1);
      chk("directed_load_err", {31'd0, load_err}, {31'd0, err});
      @(posedge clk); #1;
      do_fetch(6'd0, 1); do_fetch(6'd1, 1); do_fetch(6'd2, 1);
      do_fetch(6'd0, 1); do_fetch(6'd1, 1); do_fetch(6'd3, 1);
      @(negedge clk);
      chk("halt_sticky", {31'd0, fetch_halt}, 32'd1);
      chk("halt_run_low", {31'd0, cpu_run}, 32'd0);
      chk("halt_instr_held", fetch_instr, 32'd0);
      @(posedge clk); #1;
      queues_empty("directed");

      // Partial word then ld_done: sticky error, no writes, reset recovers
      do_reset();
      b = '{8'hAA, 8'hBB};
      model_load(b, 1'b1, err);
      drive_load(b, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err_load_err", {31'd0, load_err}, {31'd0, err});
      chk("err_cpu_run", {31'd0, cpu_run}, 32'd0);
      chk("err_ld_ready", {31'd0, ld_ready}, 32'd0);
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      chk("err_reset_ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("err_reset_load_err", {31'd0, load_err}, 32'd0);
      @(posedge clk); #1;
      queues_empty("error");

      // Full memory: 64 words, no sentinel, extra loader activity ignored
      do_reset();
      b = {};
      for (int i = 0; i < 4 * DEPTH; i++) b.push_back(8'($urandom));
      model_load(b, 1'b0, err);
      drive_load(b, 0);
      wait_run();
      for (int i = 0; i < 6; i++) begin
         ld_valid = 1'b1; ld_byte = 8'($urandom); ld_done = (i == 3);
         @(posedge clk); #1;
      end
      ld_valid = 1'b0; ld_done = 1'b0;
      chk("full_still_run", {31'd0, cpu_run}, 32'd1);
      for (int i = 0; i < 30; i++) do_fetch(6'($urandom), $urandom_range(0, 3) != 0);
      repeat (2) @(posedge clk); #1;
      queues_empty("full");

      // 4th byte and ld_done together: write, then sentinel, no error
      do_reset();
      b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      model_load(b, 1'b1, err);
      drive_load(b, 2);
      wait_run();
      chk("same_cycle_no_err", {31'd0, load_err}, {31'd0, err});
      do_fetch(6'd0, 1); do_fetch(6'd1, 1);
      repeat (2) @(posedge clk); #1;
      queues_empty("same_cycle");

      // Random images and random fetch traffic
      for (int it = 0; it < 4; it++) begin
         do_reset();
         nw = $urandom_range(1, 10);
         b = {};
         for (int i = 0; i < 4 * nw; i++) b.push_back(8'($urandom));
         model_load(b, 1'b1, err);
         drive_load(b, ($urandom_range(0, 1) != 0) ? 1 : 2);
         wait_run();
         for (int i = 0; i < 40; i++)
            do_fetch(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, nw + 1)),
                     $urandom_range(0, 2) != 0);
         repeat (2) @(posedge clk); #1;
         queues_empty("random");
      end

      // Reset while a fetch is in flight: drops to LOAD, memory untouched
      do_reset();
      b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      model_load(b, 1'b1, err);
      drive_load(b, 1);
      wait_run();
      do_fetch(6'd0, 1);
      fetch_req = 1'b1; fetch_addr = 6'd1; rst_n = 1'b0;
      @(posedge clk); #1;
      fetch_req = 1'b0;
      @(negedge clk);
      chk("midrun_rst_valid", {31'd0, fetch_valid}, 32'd0);
      chk("midrun_rst_cpu_run", {31'd0, cpu_run}, 32'd0);
      chk("midrun_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      halted_m = 0;
      repeat (2) @(posedge clk); #1;
      chk("midrun_mem0", mem[0], ref_mem[0]);
      chk("midrun_mem1", mem[1], ref_mem[1]);
      chk("midrun_mem2", mem[2], ref_mem[2]);
      queues_empty("midrun");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
